if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the program
//  counter, drives the word address into instruction_memory (async read, same
//  cycle) and captures the returned word into the IF/ID pipeline register.
//  Honours stall requests from the hazard unit and PC redirects (taken branch /
//  JAL / JALR) from EX. Redirects squash the wrong-path fetch with a NOP bubble.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0013  bubble encoding (addi x0,x0,0) placed in IF/ID
//  IMEM_AW    10             byte-address width covered by imem (1 KB); higher PC bits => fault
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  stall          in   1   hazard unit: hold PC and IF/ID contents
//  redirect       in   1   EX: taken branch/jump this cycle
//  redirect_pc    in   32  target byte address for redirect
//  imem_addr      out  32  byte address to instruction_memory (= pc_q)
//  imem_instr     in   32  instruction word returned combinationally
//  id_pc          out  32  PC of instruction held in IF/ID
//  id_pc_plus4    out  32  id_pc + 4 (link value for JAL/JALR)
//  id_instr       out  32  instruction held in IF/ID
//  id_valid       out  1   IF/ID holds a real (non-bubble) instruction
//  id_fault       out  1   IF/ID entry was fetched from misaligned/out-of-range PC
//  fetch_count    out  32  number of valid instructions delivered to IF/ID
// BEHAVIOUR
//  - One clock (clk); reset is synchronous, active-high (rst). No async paths.
//  - Reset values: pc_q=RESET_PC, id_pc=0, id_pc_plus4=4, id_instr=NOP_INSTR,
//    id_valid=0, id_fault=0, fetch_count=0. imem_addr follows pc_q.
//  - Next-state priority per cycle: rst > redirect > stall > sequential.
//  - Sequential: pc_q<=pc_q+4 (mod 2^32; 0xFFFF_FFFC wraps to 0);
//    IF/ID <= {pc_q, pc_q+4, fetched word, valid=1, fault}.
//  - Stall (no redirect): pc_q and all IF/ID fields hold; fetch_count holds.
//  - Redirect (overrides stall): pc_q<=redirect_pc; IF/ID <= bubble
//    (id_instr=NOP_INSTR, id_valid=0, id_fault=0, id_pc/id_pc_plus4 hold).
//    Target instruction appears in IF/ID one cycle after pc_q takes the target.
//  - Fault: pc_q[1:0]!=0 or any pc_q[31:IMEM_AW]!=0 => fetched word replaced by
//    NOP_INSTR, id_valid=0, id_fault=1 for that entry; PC still advances by 4.
//  - fetch_count increments (wraps at 2^32) on every IF/ID load with valid=1.
//  - Latency: instruction at pc_q visible on id_* the cycle after (1 stage).
//  - Reset asserted mid-stream: all state returns to reset values next edge;
//    stall/redirect sampled in the same cycle are ignored.
//  - Deassert of rst: first fetch at RESET_PC; id_valid rises the cycle after.
// STRUCTURE
//  - Shared pipeline package/header: NOP_INSTR, RESET_PC, XLEN=32, IF/ID field
//    widths (also consumed by id_stage and hazard unit).
//  - if_stage: PC register + next-PC priority mux + fault check.
//  - Sub-module if_id_reg: IF/ID register with hold (stall) and bubble (flush)
//    controls, plus fetch_count; reused pattern for ID/EX.
//  - instruction_memory instantiated at top level, not inside this block.
// TESTING
//  1. Reset then 4 free cycles, imem preloaded -> imem_addr 0,4,8,12; id_pc 0,4,8
//     with id_valid=1 from cycle 2; fetch_count=3.
//  2. stall high 2 cycles at pc_q=0x8 -> imem_addr stays 0x8, id_* frozen,
//     fetch_count unchanged; resumes at 0xC after release.
//  3. redirect=1, redirect_pc=0x20 while id_pc=0x10 -> next cycle pc_q=0x20,
//     id_instr=0x00000013, id_valid=0; following cycle id_pc=0x20, id_valid=1.
//  4. redirect and stall both high, redirect_pc=0x30 -> pc_q=0x30, bubble in IF/ID.
//  5. redirect_pc=0x402 -> id_fault=1, id_valid=0, id_instr=NOP; pc_q=0x406 next.
//  6. rst pulsed while pc_q=0x24 with redirect=1 -> pc_q=0, id_valid=0,
//     fetch_count=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its consumers
// (id_stage, hazard unit).
//   XLEN           : datapath width
//   RESET_PC_DEF   : default PC loaded on reset
//   NOP_INSTR_DEF  : bubble encoding, addi x0,x0,0
//   IMEM_AW_DEF    : byte-address width covered by instruction memory
//   if_id_t        : IF/ID pipeline register contents
//   fetch_fault()  : true when a PC is misaligned or outside imem
package if_stage_pkg;

    localparam int          XLEN          = 32;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int          IMEM_AW_DEF   = 10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
        logic            fault;
    } if_id_t;

    function automatic logic fetch_fault(input logic [XLEN-1:0] pc, input int aw);
        return (pc[1:0] != 2'b00) || ((pc >> aw) != '0);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and bubble controls plus a counter of
// valid instructions delivered. The same pattern serves ID/EX.
//   clk, rst      : clock, synchronous active-high reset
//   hold_i        : keep current contents (stall)
//   flush_i       : insert a bubble; overrides hold, PC fields keep their value
//   entry_i       : entry to load when neither hold nor flush is active
//   entry_o       : registered entry
//   count_o       : number of loads with valid=1 (wraps)
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            flush_i,
    input  if_id_t          entry_i,
    output if_id_t          entry_o,
    output logic [XLEN-1:0] count_o
);

    if_id_t          entry_q, entry_d;
    logic [XLEN-1:0] count_q, count_d;

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (flush_i) begin
            entry_d.instr = NOP_INSTR;
            entry_d.valid = 1'b0;
            entry_d.fault = 1'b0;
        end else if (!hold_i) begin
            entry_d = entry_i;
            if (entry_i.valid) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q.pc       <= '0;
            entry_q.pc_plus4 <= 32'd4;
            entry_q.instr    <= NOP_INSTR;
            entry_q.valid    <= 1'b0;
            entry_q.fault    <= 1'b0;
            count_q          <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign entry_o = entry_q;
    assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux
// (redirect > stall > sequential) and fetch fault check. Instruction memory
// lives outside; its word comes back combinationally on imem_instr.
//   clk, rst       : clock, synchronous active-high reset
//   stall          : hold PC and IF/ID
//   redirect       : taken branch/jump from EX, squashes the wrong-path fetch
//   redirect_pc    : redirect target
//   imem_addr      : byte address to instruction memory (= pc_q)
//   imem_instr     : fetched word
//   id_pc, id_pc_plus4, id_instr, id_valid, id_fault : IF/ID contents
//   fetch_count    : valid instructions delivered to IF/ID
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          IMEM_AW   = IMEM_AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [XLEN-1:0] id_instr,
    output logic            id_valid,
    output logic            id_fault,
    output logic [XLEN-1:0] fetch_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            fault;
    if_id_t          fetch_entry;
    if_id_t          id_entry;

    assign pc_plus4 = pc_q + 32'd4;
    assign fault    = fetch_fault(pc_q, IMEM_AW);

    // A faulting fetch never exposes whatever the memory returned.
    always_comb begin
        fetch_entry.pc       = pc_q;
        fetch_entry.pc_plus4 = pc_plus4;
        fetch_entry.instr    = fault ? NOP_INSTR : imem_instr;
        fetch_entry.valid    = ~fault;
        fetch_entry.fault    = fault;
    end

    always_comb begin
        pc_d = pc_plus4;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (stall),
        .flush_i (redirect),
        .entry_i (fetch_entry),
        .entry_o (id_entry),
        .count_o (fetch_count)
    );

    assign imem_addr   = pc_q;
    assign id_pc       = id_entry.pc;
    assign id_pc_plus4 = id_entry.pc_plus4;
    assign id_instr    = id_entry.instr;
    assign id_valid    = id_entry.valid;
    assign id_fault    = id_entry.fault;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] id_pc, id_pc_plus4, id_instr, fetch_count;
    logic        id_valid, id_fault;

    int pass_cnt = 0;
    int total    = 0;

    // reference model state
    logic [31:0] m_pc, m_id_pc, m_id_p4, m_id_instr, m_cnt;
    logic        m_valid, m_fault;

    always #5 clk = ~clk;

    // Behavioural instruction memory: a hash of the address so every
    // location (including out-of-range ones) returns a distinctive word.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0003;
    endfunction

    assign imem_instr = imem_word(imem_addr);

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .id_fault    (id_fault),
        .fetch_count (fetch_count)
    );

    function automatic logic [193:0] observed();
        return {imem_addr, id_pc, id_pc_plus4, id_instr, id_valid, id_fault, fetch_count};
    endfunction

    function automatic logic [193:0] expected();
        return {m_pc, m_id_pc, m_id_p4, m_id_instr, m_valid, m_fault, m_cnt};
    endfunction

    // Drive one cycle of inputs, advance the model by its rules, wait for the edge.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] rp);
        logic bad;
        rst = r; stall = s; redirect = d; redirect_pc = rp;
        if (r) begin
            m_pc = 32'h0; m_id_pc = 32'h0; m_id_p4 = 32'd4; m_id_instr = NOP;
            m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'h0;
        end else if (d) begin
            m_pc = rp; m_id_instr = NOP; m_valid = 1'b0; m_fault = 1'b0;
        end else if (!s) begin
            bad = (m_pc % 4 != 0) || (m_pc >= 32'd1024);
            m_id_pc    = m_pc;
            m_id_p4    = m_pc + 32'd4;
            m_id_instr = bad ? NOP : imem_word(m_pc);
            m_valid    = !bad;
            m_fault    = bad;
            if (!bad) m_cnt = m_cnt + 32'd1;
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h40);
        total++;
        if (observed() !== {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_state got=%h want=%h", observed(),
                     {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0});
        else pass_cnt++;
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [4];
        cycle(1, 0, 0, 0);
        addrs[0] = imem_addr;
        for (int i = 1; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            addrs[i] = imem_addr;
            total++;
            if (observed() !== expected())
                $display("FAIL seq_cycle%0d got=%h want=%h", i, observed(), expected());
            else pass_cnt++;
        end
        total++;
        if ({addrs[0], addrs[1], addrs[2], addrs[3]} !== {32'h0, 32'h4, 32'h8, 32'hC})
            $display("FAIL seq_addrs got=%h %h %h %h want=0 4 8 c",
                     addrs[0], addrs[1], addrs[2], addrs[3]);
        else pass_cnt++;
        total++;
        if ({id_pc, id_valid, fetch_count, id_instr} !== {32'h8, 1'b1, 32'd3, imem_word(32'h8)})
            $display("FAIL seq_final id_pc=%h valid=%b count=%0d instr=%h want 8 1 3 %h",
                     id_pc, id_valid, fetch_count, id_instr, imem_word(32'h8));
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [193:0] frozen;
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        frozen = observed();
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        total++;
        if (observed() !== frozen || imem_addr !== 32'h8 || fetch_count !== 32'd2)
            $display("FAIL stall_hold got=%h want=%h", observed(), frozen);
        else pass_cnt++;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        total++;
        if (imem_addr !== 32'h10 || id_pc !== 32'hC || fetch_count !== 32'd4)
            $display("FAIL stall_resume addr=%h id_pc=%h count=%0d want 10 c 4",
                     imem_addr, id_pc, fetch_count);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        total++;
        if (id_pc !== 32'h10)
            $display("FAIL redir_setup id_pc=%h want 10", id_pc);
        else pass_cnt++;
        cycle(0, 0, 1, 32'h20);
        total++;
        if ({imem_addr, id_instr, id_valid, id_pc} !== {32'h20, NOP, 1'b0, 32'h10})
            $display("FAIL redir_bubble addr=%h instr=%h valid=%b id_pc=%h want 20 13 0 10",
                     imem_addr, id_instr, id_valid, id_pc);
        else pass_cnt++;
        cycle(0, 0, 0, 0);
        total++;
        if ({id_pc, id_valid, id_instr, imem_addr} !== {32'h20, 1'b1, imem_word(32'h20), 32'h24})
            $display("FAIL redir_target id_pc=%h valid=%b instr=%h addr=%h",
                     id_pc, id_valid, id_instr, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_redirect_stall();
        logic [31:0] cnt_before;
        cnt_before = fetch_count;
        cycle(0, 1, 1, 32'h30);
        total++;
        if ({imem_addr, id_instr, id_valid, id_fault, fetch_count} !==
            {32'h30, NOP, 1'b0, 1'b0, cnt_before})
            $display("FAIL redir_over_stall addr=%h instr=%h valid=%b fault=%b count=%0d",
                     imem_addr, id_instr, id_valid, id_fault, fetch_count);
        else pass_cnt++;
    endtask

    task automatic test_fault();
        cycle(0, 0, 1, 32'h402);
        cycle(0, 0, 0, 0);
        total++;
        if ({id_fault, id_valid, id_instr, imem_addr, id_pc} !==
            {1'b1, 1'b0, NOP, 32'h406, 32'h402})
            $display("FAIL fault_entry fault=%b valid=%b instr=%h addr=%h id_pc=%h",
                     id_fault, id_valid, id_instr, imem_addr, id_pc);
        else pass_cnt++;
        cycle(0, 0, 1, 32'h3FC);
        cycle(0, 0, 0, 0);
        total++;
        if ({id_fault, id_valid, id_instr} !== {1'b0, 1'b1, imem_word(32'h3FC)})
            $display("FAIL fault_last_word fault=%b valid=%b instr=%h",
                     id_fault, id_valid, id_instr);
        else pass_cnt++;
        cycle(0, 0, 0, 0);
        total++;
        if ({id_fault, id_valid, id_pc} !== {1'b1, 1'b0, 32'h400})
            $display("FAIL fault_range fault=%b valid=%b id_pc=%h want 1 0 400",
                     id_fault, id_valid, id_pc);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        total++;
        if ({imem_addr, id_pc_plus4, id_fault} !== {32'h0, 32'h0, 1'b1})
            $display("FAIL pc_wrap addr=%h p4=%h fault=%b want 0 0 1",
                     imem_addr, id_pc_plus4, id_fault);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        cycle(0, 0, 1, 32'h24);
        cycle(0, 0, 0, 0);
        total++;
        if (imem_addr !== 32'h28 || fetch_count === 32'h0)
            $display("FAIL mid_setup addr=%h count=%0d", imem_addr, fetch_count);
        else pass_cnt++;
        cycle(0, 0, 1, 32'h24);
        cycle(1, 0, 1, 32'h80);
        total++;
        if (observed() !== {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0})
            $display("FAIL mid_reset got=%h want=%h", observed(),
                     {32'h0, 32'h0, 32'h4, NOP, 1'b0, 1'b0, 32'h0});
        else pass_cnt++;
        cycle(0, 0, 0, 0);
        total++;
        if ({imem_addr, id_pc, id_valid} !== {32'h4, 32'h0, 1'b1})
            $display("FAIL mid_restart addr=%h id_pc=%h valid=%b", imem_addr, id_pc, id_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic        r, s, d;
        logic [31:0] rp;
        int          errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 2);
            d = ($urandom_range(0, 99) < 15);
            s = ($urandom_range(0, 99) < 25);
            case ($urandom_range(0, 9))
                0:       rp = $urandom();
                1:       rp = 32'hFFFF_FFF0 | {28'h0, $urandom_range(0, 3), 2'b00};
                default: rp = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            cycle(r, s, d, rp);
            total++;
            if (observed() !== expected()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle%0d got=%h want=%h", i, observed(), expected());
            end else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_fault();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
